// File: rtl/param_cache.sv
// rtl/param_cache.sv - direct-mapped read-only parameter cache with line fill and sequential flush
module param_cache #(
    parameter int ADDR_W      = 15,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int SETS        = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic [ADDR_W-1:0]             req_addr,
    output logic                          req_ready,
    output logic                          resp_valid,
    output logic [WORD_W-1:0]             resp_data,
    output logic                          resp_hit,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ready,
    input  logic [BLOCK_WORDS*WORD_W-1:0] mem_data,
    input  logic                          flush,
    output logic [31:0]                   access_count,
    output logic [31:0]                   hit_count
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_FLUSH} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [IDX_W-1:0]                fidx_q, fidx_d;
    logic                            flush_pend_q, flush_pend_d;
    logic [SETS-1:0]                 valid_q;
    logic                            req_ready_q, req_ready_d;
    logic                            resp_valid_q, resp_valid_d;
    logic                            resp_hit_q, resp_hit_d;
    logic [WORD_W-1:0]               resp_data_q, resp_data_d;
    logic                            mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]               mem_addr_q, mem_addr_d;
    logic [31:0]                     acc_cnt_q, acc_cnt_d;
    logic [31:0]                     hit_cnt_q, hit_cnt_d;

    logic [TAG_W-1:0]                tag_mem  [SETS];
    logic [BLOCK_WORDS*WORD_W-1:0]   data_mem [SETS];

    logic [OFF_W-1:0]                off;
    logic [IDX_W-1:0]                idx;
    logic [TAG_W-1:0]                tag;
    logic                            hit;
    logic                            fill_done;
    logic [BLOCK_WORDS*WORD_W-1:0]   line_rd;

    assign off       = addr_q[OFF_W-1:0];
    assign idx       = addr_q[OFF_W +: IDX_W];
    assign tag       = addr_q[ADDR_W-1 -: TAG_W];
    assign line_rd   = data_mem[idx];
    assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
    assign fill_done = (state_q == S_FILL) && mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            fidx_q       <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            acc_cnt_q    <= '0;
            hit_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            fidx_q       <= fidx_d;
            flush_pend_q <= flush_pend_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_data_q  <= resp_data_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            acc_cnt_q    <= acc_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
            if (state_q == S_FLUSH) begin
                valid_q[fidx_q] <= 1'b0;
            end else if (fill_done) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Arrays carry no reset; a line only becomes visible through its valid bit.
    always_ff @(posedge clk) begin
        if (fill_done && !rst) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        fidx_d       = fidx_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            S_IDLE: begin
                if (flush || flush_pend_q) begin
                    state_d      = S_FLUSH;
                    fidx_d       = '0;
                    flush_pend_d = 1'b0;
                end else if (req_valid && req_ready_q) begin
                    state_d = S_LOOKUP;
                    addr_d  = req_addr;
                end
            end
            S_LOOKUP: begin
                flush_pend_d = flush_pend_q | flush;
                state_d      = hit ? S_IDLE : S_FILL;
            end
            S_FILL: begin
                flush_pend_d = flush_pend_q | flush;
                if (mem_ready) state_d = S_IDLE;
            end
            default: begin
                fidx_d = fidx_q + 1'b1;
                if (fidx_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready_d  = (state_d == S_IDLE) && !flush_pend_d;
        resp_valid_d = 1'b0;
        resp_hit_d   = 1'b0;
        resp_data_d  = resp_data_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        acc_cnt_d    = acc_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        if (state_q == S_LOOKUP) begin
            if (hit) begin
                resp_valid_d = 1'b1;
                resp_hit_d   = 1'b1;
                resp_data_d  = line_rd[off*WORD_W +: WORD_W];
            end else begin
                mem_req_d  = 1'b1;
                mem_addr_d = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
        end else if (fill_done) begin
            mem_req_d    = 1'b0;
            resp_valid_d = 1'b1;
            resp_data_d  = mem_data[off*WORD_W +: WORD_W];
        end
        if (resp_valid_d && acc_cnt_q != 32'hFFFF_FFFF) acc_cnt_d = acc_cnt_q + 32'd1;
        if (resp_hit_d && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
    end

    assign req_ready    = req_ready_q & ~flush;
    assign resp_valid   = resp_valid_q;
    assign resp_hit     = resp_hit_q;
    assign resp_data    = resp_data_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign access_count = acc_cnt_q;
    assign hit_count    = hit_cnt_q;
endmodule

// File: tb/tb_param_cache.sv
// tb/tb_param_cache.sv - scoreboard bench for param_cache with a line-fill memory responder
module tb_param_cache;
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [14:0]  req_addr;
    logic         req_ready;
    logic         resp_valid;
    logic [31:0]  resp_data;
    logic         resp_hit;
    logic         mem_req;
    logic [14:0]  mem_addr;
    logic         mem_ready;
    logic [127:0] mem_data;
    logic         flush;
    logic [31:0]  access_count;
    logic [31:0]  hit_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int resp_cnt = 0;
    int exp_acc = 0;
    int exp_hits = 0;
    int mem_delay = 0;
    logic rsp_rdy, tst_rdy, mem_hold;
    logic [14:0] exp_mem_addr, a0;
    logic [32:0] exp_q[$];
    logic mvalid [1024];
    logic [2:0] mtag [1024];

    param_cache dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .flush(flush), .access_count(access_count), .hit_count(hit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line at base 0x0004 is {33,22,11,00}; other lines get distinct upper bits.
    function automatic logic [31:0] word_of(input logic [14:0] a);
        logic [31:0] base;
        base = {17'd0, a[14:2], 2'b00};
        return ((base - 32'd4) << 12) | ({30'd0, a[1:0]} * 32'h11);
    endfunction

    function automatic logic [127:0] line_of(input logic [14:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = word_of({a[14:2], 2'(i)});
        return l;
    endfunction

    assign mem_ready = rsp_rdy | tst_rdy;
    assign mem_data  = line_of(mem_addr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) mvalid[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst && resp_valid) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexp_resp", 64'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                chk("resp_data", resp_data, e[31:0]);
                chk("resp_hit", resp_hit, e[32]);
                if (e[32]) chk("hit_lat", 64'(cyc - acc_cyc + 1), 2);
            end
        end
    end

    always begin
        @(posedge clk); #1;
        if (mem_req && !mem_hold && !rst) begin
            chk("mem_addr", mem_addr, exp_mem_addr);
            a0 = mem_addr;
            for (int k = 0; k < mem_delay; k++) begin
                @(posedge clk); #1;
                chk("fill_req_hold", mem_req, 1);
                chk("fill_addr_hold", mem_addr, a0);
                chk("fill_rdy_low", req_ready, 0);
            end
            rsp_rdy = 1'b1;
            @(posedge clk); #1;
            rsp_rdy = 1'b0;
        end
    end

    task automatic do_read(input logic [14:0] a, input int dly);
        logic [9:0] ix;
        logic [2:0] tg;
        logic eh, saw_mem;
        int n, c0;
        ix = a[11:2];
        tg = a[14:12];
        eh = mvalid[ix] && (mtag[ix] == tg);
        exp_q.push_back({eh, word_of(a)});
        exp_acc++;
        if (eh) exp_hits++;
        mvalid[ix] = 1'b1;
        mtag[ix] = tg;
        exp_mem_addr = {a[14:2], 2'b00};
        mem_delay = dly;
        req_addr = a;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 2000) begin @(posedge clk); #1; n++; end
        chk("acc_wait", 64'(n < 2000), 1);
        c0 = resp_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc_cyc = cyc;
        saw_mem = 1'b0;
        n = 0;
        while (resp_cnt == c0 && n < 100) begin
            if (mem_req) saw_mem = 1'b1;
            @(posedge clk); #2;
            n++;
        end
        chk("resp_wait", 64'(n < 100), 1);
        chk("mem_used", saw_mem, !eh);
        chk("acc_cnt", access_count, exp_acc);
        chk("hit_cnt", hit_count, exp_hits);
        repeat (2) @(posedge clk);
        #1;
        chk("one_resp", 64'(resp_cnt), 64'(c0 + 1));
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        rsp_rdy = 1'b0; tst_rdy = 1'b0; mem_hold = 1'b0; exp_mem_addr = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_acc", access_count, 0);
        chk("rst_hit", hit_count, 0);

        do_read(15'h0005, 0);
        do_read(15'h0006, 0);
        do_read(15'h1005, 0);
        do_read(15'h0005, 0);

        flush = 1'b1; req_valid = 1'b1; req_addr = 15'h1005;
        #1 chk("flush_prio_rdy", req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        model_clear();
        n = 0;
        while (!req_ready && n < 3000) begin @(posedge clk); #1; n++; end
        chk("flush_len", 64'(n), 1024);
        chk("flush_no_acc", access_count, exp_acc);
        do_read(15'h1005, 0);

        do_read(15'h2008, 7);
        do_read(15'h2009, 0);

        fork
            do_read(15'h0005, 3);
            begin
                int m;
                m = 0;
                while (!mem_req && m < 50) begin @(posedge clk); #1; m++; end
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
            end
        join
        model_clear();
        chk("pend_flush_rdy", req_ready, 0);
        do_read(15'h0005, 0);

        mem_hold = 1'b1;
        req_addr = 15'h3010; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 2000) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
        chk("rf_mem_req_seen", mem_req, 1);
        tst_rdy = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; tst_rdy = 1'b0; mem_hold = 1'b0;
        model_clear();
        exp_acc = 0; exp_hits = 0;
        chk("rf_mem_req", mem_req, 0);
        chk("rf_resp_valid", resp_valid, 0);
        chk("rf_acc", access_count, 0);
        chk("rf_hit", hit_count, 0);
        chk("rf_ready", req_ready, 1);
        do_read(15'h3010, 0);
        do_read(15'h3013, 0);

        repeat (3) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/param_cache.md
PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word-address width.
REQ-002 SHALL have parameter WORD_W, default 32, data word width.
REQ-003 SHALL have parameter BLOCK_WORDS, default 4, words per line; power of two, at least 2.
REQ-004 SHALL have parameter SETS, default 1024, direct-mapped lines; power of two; TAG_W = ADDR_W - log2(SETS) - log2(BLOCK_WORDS), at least 1.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  CPU read request.
REQ-008 SHALL have port req_addr  input  ADDR_W  word address: [tag | index | offset], offset in the LSBs.
REQ-009 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high at an edge.
REQ-010 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port resp_data  output  WORD_W  requested word.
REQ-012 SHALL have port resp_hit  output  1  response was a hit.
REQ-013 SHALL have port mem_req  output  1  line-fill request to main memory.
REQ-014 SHALL have port mem_addr  output  ADDR_W  line base address: req_addr with the offset bits zeroed.
REQ-015 SHALL have port mem_ready  input  1  mem_data valid this cycle.
REQ-016 SHALL have port mem_data  input  BLOCK_WORDS*WORD_W  full line; word i at bits [i*WORD_W +: WORD_W].
REQ-017 SHALL have port flush  input  1  invalidate-all request.
REQ-018 SHALL have port access_count  output  32  responses delivered.
REQ-019 SHALL have port hit_count  output  32  hit responses delivered.

Function
REQ-020 SHALL implement FSM states IDLE, LOOKUP, FILL and FLUSH; all outputs registered.
REQ-021 SHALL drive req_ready high only in IDLE with flush low.
REQ-022 SHALL, on acceptance, register req_addr and move IDLE -> LOOKUP.
REQ-023 SHALL, in LOOKUP on a hit (valid bit set, stored tag equal), assert resp_valid=1, resp_hit=1 and resp_data=line[offset] for the next cycle only, then return to IDLE; hit latency is 2 edges from acceptance.
REQ-024 SHALL, in LOOKUP on a miss, set mem_req=1 and mem_addr=line base, then move to FILL.
REQ-025 SHALL, in FILL, hold mem_req and mem_addr stable until mem_ready is sampled high.
REQ-026 SHALL, at the edge where mem_ready is sampled high in FILL: capture mem_data into the line, write the tag, set the valid bit, drop mem_req, assert resp_valid=1, resp_hit=0 and resp_data=mem_data word[offset] for one cycle, and return to IDLE.
REQ-027 SHALL ignore mem_ready outside FILL.
REQ-028 SHALL replace the resident line on a conflicting tag; there is no write path.
REQ-029 SHALL, when flush is high in IDLE, take priority over a simultaneous req_valid, enter FLUSH and clear one valid bit per cycle, indices 0..SETS-1 in order, returning to IDLE after SETS cycles; req_ready stays low throughout.
REQ-030 SHALL latch a flush asserted in LOOKUP or FILL as pending and service it on the next IDLE cycle, after the current response.
REQ-031 SHALL increment access_count on every resp_valid, and hit_count on every resp_valid with resp_hit=1; both saturate at 32'hFFFFFFFF.

Reset
REQ-032 SHALL, on rst, clear all valid bits in one cycle, set state=IDLE, req_ready=1, resp_valid=0, resp_hit=0, resp_data=0, mem_req=0, mem_addr=0, access_count=0, hit_count=0, and clear any pending flush; tag and data arrays are not reset.
REQ-033 SHALL, on rst during FILL or FLUSH, abandon the operation with no response and no line write, taking priority over mem_ready in the same cycle.

Verification (defaults: offset 2b, index 10b, tag 3b)
REQ-034 SHALL cover cold miss: after reset read 15'h0005; mem returns line {D3..D0}={33,22,11,00} -> mem_addr=15'h0004, resp_valid with resp_hit=0 and resp_data=32'h11; access_count=1, hit_count=0.
REQ-035 SHALL cover hit: then read 15'h0006 -> resp_data=32'h22 and resp_hit=1 exactly 2 edges after acceptance, mem_req stays 0, hit_count=1.
REQ-036 SHALL cover conflict: read 15'h1005 (same index, tag 1) -> miss with mem_addr=15'h1004; then read 15'h0005 -> miss again.
REQ-037 SHALL cover flush: flush and req_valid high together in IDLE -> FLUSH takes priority, req_ready low for 1024 cycles; then read 15'h1005 -> miss.
REQ-038 SHALL cover reset mid-fill: assert rst with mem_ready high in FILL -> no resp_valid, mem_req=0 next cycle, counters 0; then read the same address -> miss.
REQ-039 SHALL cover backpressure: mem_ready delayed 7 cycles -> mem_req and mem_addr stable throughout, req_ready low, exactly one response.
